text_buf_ctrl: RTL
==================

# text_buf_ctrl

Write-side controller for the 80x30 text-mode character buffer. It accepts ASCII characters, arrow-key pulses and a clear-screen request, and owns the cursor position. It sequences every write into the character RAM's write port (address `{y[4:0],x[6:0]}`), including multi-cycle full-screen clears. It sits between the keyboard/ASCII conversion path and the dual-port character RAM; the pixel-side read port is untouched.

## Interface
- `COLS`, 80, characters per row; x range 0..COLS-1
- `ROWS`, 30, rows per screen; y range 0..ROWS-1
- `DATA_WIDTH`, 7, character code width

- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `key_valid`  in  1  character offered on `key_code`
- `key_code`  in  DATA_WIDTH  ASCII code
- `key_ready`  out  1  controller can accept a character this cycle
- `up`, `down`, `left`, `right`  in  1 each  single-cycle cursor-move pulses
- `clr_req`  in  1  single-cycle clear-screen request
- `ram_we`  out  1  write strobe to character RAM
- `ram_addr`  out  12  write address `{y[4:0],x[6:0]}`
- `ram_din`  out  DATA_WIDTH  write data
- `cursor_x`  out  7  current cursor column
- `cursor_y`  out  5  current cursor row
- `busy`  out  1  high while a clear is in progress

## Operation
- States: IDLE, WRITE, CLEAR.
- **IDLE:**
  - `key_ready=1`.
  - A character is accepted when `key_valid & key_ready`. Next state is WRITE.
- **WRITE (one cycle):**
  - `ram_we=1`, `key_ready=0`. Next state is IDLE.
  - Printable code 0x20..0x7E: write the code at the pre-advance cursor, then advance the cursor.
  - Advance rule: x+1. At x=COLS-1, go to x=0, y+1. At (COLS-1, ROWS-1), go to (0,0).
  - Backspace 0x08: move the cursor back and write 0x20 at the new position.
    - Back rule: x-1. At x=0, go to x=COLS-1, y-1.
    - At (0,0) the cursor stays and 0x20 is written at (0,0).
  - Carriage return 0x0D: no write (`ram_we=0` in WRITE). Cursor goes to x=0 and y+1, with y wrapping ROWS-1→0.
  - Any other code: consumed, no write, cursor unchanged.
- **Arrows** (IDLE only, no RAM write):
  - Right and left wrap within the row: right at COLS-1 goes to 0; left at 0 goes to COLS-1.
  - Down and up wrap within the column: down at ROWS-1 goes to 0; up at 0 goes to ROWS-1.
  - Priority among simultaneous arrows: right > left > down > up.
  - An arrow arriving in the same cycle as an accepted key is dropped.
  - Arrows arriving in WRITE or CLEAR are dropped.
- **CLEAR:**
  - Writes 0x20 to every visible cell in row-major order: (0,0), (1,0), …, (COLS-1,0), (0,1), …, (COLS-1,ROWS-1).
  - One cell per cycle: COLS*ROWS = 2400 write cycles.
  - Addresses with x ≥ COLS are never written.
  - On the last write the cursor goes to (0,0) and the next state is IDLE.
  - `busy=1` and `key_ready=0` throughout.
- **clr_req handling:**
  - Priority in IDLE: `clr_req` > key > arrow. If a key and `clr_req` coincide, the key is not accepted (`key_ready` drops the same cycle, combinationally from `clr_req`).
  - `clr_req` in WRITE is latched into a pending flag; CLEAR starts right after WRITE.
  - `clr_req` during CLEAR is ignored.
- **Reset mid-operation:** any state → IDLE. Cursor goes to (0,0), the clear counter and pending flag are cleared, and a clear in progress is abandoned.

## Timing
- **Reset values:** `ram_we=0`, `ram_addr=0`, `ram_din=0`, `cursor_x=0`, `cursor_y=0`, `busy=0`, `key_ready=1` (when `clr_req=0`).
- **Registered outputs:** `ram_we`, `ram_addr`, `ram_din`, `busy`, `cursor_*`.
- **Key path, accepted at edge N:**
  - Cycle N+1: `ram_we/addr/din` carry the write.
  - Cycle N+1: `cursor_*` already show the post-update position.
- **Throughput:** one key per 2 cycles.
- **Clear:**
  - Accepted at edge N; first write appears in cycle N+1.
  - Last write appears in cycle N+2400.
  - `busy` falls and the cursor reads (0,0) in cycle N+2401, which is also the first cycle `key_ready=1`.
- **Arithmetic:** cursor math is modulo COLS/ROWS, never modulo a power of two. The clear counter reuses the x/y counters, not a flat 12-bit count.

## Structure
- **Shared package `text_pkg`:**
  - Constants: `COLS`, `ROWS`, `ASCII_SPACE=7'h20`, `ASCII_BS=7'h08`, `ASCII_CR=7'h0D`, `ADDR_W=12`.
  - State enum for IDLE/WRITE/CLEAR.
- **Sub-module `text_cursor`:** x/y registers with wrap-aware inc/dec/newline/home operations. The FSM drives it for both normal cursor moves and the clear sweep.

## Test plan
- **Printable key:** reset, then 'A' (0x41) → one cycle `ram_we=1`, `ram_addr=0x000`, `ram_din=0x41`; `cursor_x=1`.
- **Advance wrap:** cursor at (79,29), type 0x42 → write at `{5'd29,7'd79}`; cursor (0,0).
- **Backspace:** at (0,1) → write 0x20 at `{5'd0,7'd79}`, cursor (79,0). At (0,0) → write 0x20 at 0x000, cursor stays.
- **Arrows:** left at x=0 → x=79. Up at y=0 → y=29. Right+left same cycle → only right. Arrow with accepted key → arrow dropped.
- **Clear with collisions:** `clr_req` with `key_valid` in IDLE → key not accepted. Exactly 2400 writes of 0x20, no address with x ≥ 80, `busy` high for 2400 cycles, cursor (0,0) after.
- **Reset and pending clear:** reset asserted at write 1000 of a clear → outputs at reset values immediately, no further writes. `clr_req` during WRITE → clear starts the following cycle.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, enums and address payload for the text-mode write-side controller.
package text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned X_W    = 7;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned ADDR_W = 12;

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  localparam logic [DATA_W-1:0] ASCII_SPACE = 7'h20;
  localparam logic [DATA_W-1:0] ASCII_TILDE = 7'h7E;
  localparam logic [DATA_W-1:0] ASCII_BS    = 7'h08;
  localparam logic [DATA_W-1:0] ASCII_CR    = 7'h0D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    CUR_HOLD    = 4'd0,
    CUR_INC     = 4'd1,
    CUR_DEC     = 4'd2,
    CUR_NEWLINE = 4'd3,
    CUR_HOME    = 4'd4,
    CUR_RIGHT   = 4'd5,
    CUR_LEFT    = 4'd6,
    CUR_DOWN    = 4'd7,
    CUR_UP      = 4'd8
  } cur_op_e;

  // Character RAM write address layout: row in the upper bits, column below.
  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } cell_t;

endpackage

// File: rtl/text_cursor.sv
// Cursor x/y registers with wrap-aware moves; also serves as the clear-sweep counter.
module text_cursor
  import text_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  cur_op_e        op,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] inc_x_c,
  output logic [Y_W-1:0] inc_y_c,
  output logic [X_W-1:0] dec_x_c,
  output logic [Y_W-1:0] dec_y_c
);

  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;
  logic [Y_W-1:0] y_wrap_inc;
  logic [Y_W-1:0] y_wrap_dec;
  logic [X_W-1:0] x_wrap_inc;
  logic [X_W-1:0] x_wrap_dec;

  // Single-axis wraps, modulo COLS/ROWS.
  always_comb begin
    x_wrap_inc = (x == X_LAST) ? '0 : x + X_W'(1);
    x_wrap_dec = (x == '0) ? X_LAST : x - X_W'(1);
    y_wrap_inc = (y == Y_LAST) ? '0 : y + Y_W'(1);
    y_wrap_dec = (y == '0) ? Y_LAST : y - Y_W'(1);
  end

  // Row-major advance and retreat; retreat saturates at the home cell.
  always_comb begin
    inc_x_c = x_wrap_inc;
    inc_y_c = (x == X_LAST) ? y_wrap_inc : y;
    dec_x_c = x;
    dec_y_c = y;
    if (x != '0) begin
      dec_x_c = x - X_W'(1);
    end else if (y != '0) begin
      dec_x_c = X_LAST;
      dec_y_c = y - Y_W'(1);
    end
  end

  always_comb begin
    x_next = x;
    y_next = y;
    case (op)
      CUR_INC:     begin x_next = inc_x_c; y_next = inc_y_c; end
      CUR_DEC:     begin x_next = dec_x_c; y_next = dec_y_c; end
      CUR_NEWLINE: begin x_next = '0;      y_next = y_wrap_inc; end
      CUR_HOME:    begin x_next = '0;      y_next = '0; end
      CUR_RIGHT:   x_next = x_wrap_inc;
      CUR_LEFT:    x_next = x_wrap_dec;
      CUR_DOWN:    y_next = y_wrap_inc;
      CUR_UP:      y_next = y_wrap_dec;
      default:     begin x_next = x; y_next = y; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

endmodule

// File: rtl/text_buf_ctrl.sv
// Write-side controller for the 80x30 character buffer: key writes, cursor moves, full clears.
module text_buf_ctrl
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_code,
  output logic              key_ready,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              clr_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [X_W-1:0]    cursor_x,
  output logic [Y_W-1:0]    cursor_y,
  output logic              busy
);

  state_e            state;
  state_e            state_next;
  cur_op_e           cur_op;
  logic              we_next;
  cell_t             addr_next;
  logic [DATA_W-1:0] din_next;
  logic              clr_start;
  logic              sweep_last;
  logic [X_W-1:0]    inc_x;
  logic [Y_W-1:0]    inc_y;
  logic [X_W-1:0]    dec_x;
  logic [Y_W-1:0]    dec_y;

  text_cursor u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (cur_op),
    .x       (cursor_x),
    .y       (cursor_y),
    .inc_x_c (inc_x),
    .inc_y_c (inc_y),
    .dec_x_c (dec_x),
    .dec_y_c (dec_y)
  );

  // A clear request blocks key acceptance in the same cycle.
  assign key_ready  = (state == ST_IDLE) && !clr_req;
  assign sweep_last = (cursor_x == X_LAST) && (cursor_y == Y_LAST);

  // Next-state, cursor operation and next write-port values.
  always_comb begin
    state_next = state;
    cur_op     = CUR_HOLD;
    we_next    = 1'b0;
    addr_next  = cell_t'(ram_addr);
    din_next   = ram_din;
    clr_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          clr_start = 1'b1;
        end else if (key_valid) begin
          state_next = ST_WRITE;
          if (key_code >= ASCII_SPACE && key_code <= ASCII_TILDE) begin
            we_next   = 1'b1;
            addr_next = '{y: cursor_y, x: cursor_x};
            din_next  = key_code;
            cur_op    = CUR_INC;
          end else if (key_code == ASCII_BS) begin
            we_next   = 1'b1;
            addr_next = '{y: dec_y, x: dec_x};
            din_next  = ASCII_SPACE;
            cur_op    = CUR_DEC;
          end else if (key_code == ASCII_CR) begin
            cur_op = CUR_NEWLINE;
          end
        end else if (right) begin
          cur_op = CUR_RIGHT;
        end else if (left) begin
          cur_op = CUR_LEFT;
        end else if (down) begin
          cur_op = CUR_DOWN;
        end else if (up) begin
          cur_op = CUR_UP;
        end
      end
      // A clear requested during the write cycle is taken at the exit edge.
      ST_WRITE: begin
        if (clr_req) begin
          clr_start = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cur_op = CUR_INC;
        if (sweep_last) begin
          state_next = ST_IDLE;
        end else begin
          we_next   = 1'b1;
          addr_next = '{y: inc_y, x: inc_x};
          din_next  = ASCII_SPACE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Clear start writes cell (0,0) and parks the cursor there as the sweep origin.
    if (clr_start) begin
      state_next = ST_CLEAR;
      cur_op     = CUR_HOME;
      we_next    = 1'b1;
      addr_next  = '0;
      din_next   = ASCII_SPACE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      ram_we   <= we_next;
      ram_addr <= ADDR_W'(addr_next);
      ram_din  <= din_next;
      busy     <= (state_next == ST_CLEAR);
    end
  end

endmodule
